// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory/writeback pipeline stage with blocking memory handshake, timeout and halt
module mem_wb_stage #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] ALUoutIn,
   input  logic [15:0] RtIn,
   input  logic        MemEnableIn,
   input  logic        MemWrIn,
   input  logic        HaltIn,
   input  logic        Val2RegIn,
   input  logic        RegWrIn,
   input  logic [2:0]  WrRegIn,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   output logic        wb_valid,
   output logic [15:0] wb_data,
   output logic [2:0]  wb_reg,
   output logic        wb_regwr,
   output logic        halt_out,
   output logic        err_out
);
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HALTED = 2'd2} state_t;

   // Counter reaches TIMEOUT on the same edge that leaves REQ, so compare against one less.
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] wait_cnt;
   logic       wr_q;
   logic       val2reg_q;
   logic       regwr_q;
   logic [2:0] reg_q;
   logic       mem_instr;

   assign mem_instr = in_valid && MemEnableIn && !HaltIn;
   assign mem_req   = (state == REQ);
   assign mem_wr    = mem_req && wr_q;

   always_comb begin
      stall = 1'b0;
      case (state)
         IDLE:    stall = mem_instr;
         REQ:     stall = !mem_ready;
         default: stall = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         wr_q      <= 1'b0;
         val2reg_q <= 1'b0;
         regwr_q   <= 1'b0;
         reg_q     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wb_valid  <= 1'b0;
         wb_data   <= '0;
         wb_reg    <= '0;
         wb_regwr  <= 1'b0;
         halt_out  <= 1'b0;
         err_out   <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (HaltIn) begin
                     wb_valid <= 1'b1;
                     wb_data  <= ALUoutIn;
                     wb_reg   <= WrRegIn;
                     wb_regwr <= 1'b0;
                     halt_out <= 1'b1;
                     state    <= HALTED;
                  end else if (MemEnableIn) begin
                     if (ALUoutIn[0]) begin
                        err_out  <= 1'b1;
                        halt_out <= 1'b1;
                        state    <= HALTED;
                     end else begin
                        mem_addr  <= ALUoutIn;
                        mem_wdata <= RtIn;
                        wr_q      <= MemWrIn;
                        val2reg_q <= Val2RegIn;
                        regwr_q   <= RegWrIn;
                        reg_q     <= WrRegIn;
                        wait_cnt  <= '0;
                        state     <= REQ;
                     end
                  end else begin
                     wb_valid <= 1'b1;
                     wb_data  <= ALUoutIn;
                     wb_reg   <= WrRegIn;
                     wb_regwr <= RegWrIn;
                  end
               end
            end
            REQ: begin
               if (mem_ready) begin
                  wb_valid <= 1'b1;
                  wb_data  <= val2reg_q ? mem_rdata : mem_addr;
                  wb_reg   <= reg_q;
                  wb_regwr <= regwr_q;
                  state    <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (wait_cnt == LAST_WAIT) begin
                     err_out  <= 1'b1;
                     halt_out <= 1'b1;
                     state    <= HALTED;
                  end
               end
            end
            default: state <= HALTED;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench: directed scenarios plus random traffic against a reference model
module tb_mem_wb_stage;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] ALUoutIn;
   logic [15:0] RtIn;
   logic        MemEnableIn;
   logic        MemWrIn;
   logic        HaltIn;
   logic        Val2RegIn;
   logic        RegWrIn;
   logic [2:0]  WrRegIn;
   logic        stall;
   logic        mem_req;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic        wb_valid;
   logic [15:0] wb_data;
   logic [2:0]  wb_reg;
   logic        wb_regwr;
   logic        halt_out;
   logic        err_out;

   always #5 clk = ~clk;

   mem_wb_stage #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .ALUoutIn(ALUoutIn), .RtIn(RtIn),
      .MemEnableIn(MemEnableIn), .MemWrIn(MemWrIn), .HaltIn(HaltIn), .Val2RegIn(Val2RegIn),
      .RegWrIn(RegWrIn), .WrRegIn(WrRegIn), .stall(stall), .mem_req(mem_req), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg), .wb_regwr(wb_regwr),
      .halt_out(halt_out), .err_out(err_out)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %b, required %b", name, act, exp);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h, required %h", name, act, exp);
      end
   endtask

   // Reference model: one outstanding memory transaction, sticky halt/error flags.
   bit          m_halted, m_err, m_busy, m_wr, m_v2r, m_regwr;
   int          m_waited;
   logic [2:0]  m_reg;
   logic [15:0] m_last_addr, m_last_wdata;
   bit          e_valid, e_regwr;
   logic [15:0] e_data;
   logic [2:0]  e_reg;

   function automatic bit m_stall();
      if (m_halted) return 1'b1;
      if (m_busy) return !mem_ready;
      return in_valid && MemEnableIn && !HaltIn;
   endfunction

   task automatic m_retire(input logic [15:0] d, input logic [2:0] r, input bit w);
      e_valid = 1'b1;
      e_data  = d;
      e_reg   = r;
      e_regwr = w;
   endtask

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_halted = 0; m_err = 0; m_busy = 0; m_wr = 0; m_v2r = 0; m_regwr = 0;
         m_waited = 0; m_reg = '0; m_last_addr = '0; m_last_wdata = '0;
         e_valid = 0; e_regwr = 0; e_data = '0; e_reg = '0;
      end else begin
         e_valid = 1'b0;
         if (m_halted) begin
         end else if (m_busy) begin
            if (mem_ready) begin
               m_retire(m_v2r ? mem_rdata : m_last_addr, m_reg, m_regwr);
               m_busy = 0;
            end else begin
               m_waited++;
               if (m_waited == TMO) begin
                  m_busy = 0; m_halted = 1; m_err = 1;
               end
            end
         end else if (in_valid) begin
            if (HaltIn) begin
               m_retire(ALUoutIn, WrRegIn, 1'b0);
               m_halted = 1;
            end else if (MemEnableIn && ALUoutIn[0]) begin
               m_halted = 1; m_err = 1;
            end else if (MemEnableIn) begin
               m_busy = 1; m_waited = 0;
               m_last_addr = ALUoutIn; m_last_wdata = RtIn;
               m_wr = MemWrIn; m_v2r = Val2RegIn; m_regwr = RegWrIn; m_reg = WrRegIn;
            end else begin
               m_retire(ALUoutIn, WrRegIn, RegWrIn);
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      chk1("stall", stall, m_stall());
      chk1("mem_req", mem_req, m_busy);
      chk1("mem_wr", mem_wr, m_busy && m_wr);
      chk16("mem_addr", mem_addr, m_last_addr);
      chk16("mem_wdata", mem_wdata, m_last_wdata);
      chk1("wb_valid", wb_valid, e_valid);
      if (e_valid) begin
         chk16("wb_data", wb_data, e_data);
         chk16("wb_reg", 16'(wb_reg), 16'(e_reg));
         chk1("wb_regwr", wb_regwr, e_regwr);
      end
      chk1("halt_out", halt_out, m_halted);
      chk1("err_out", err_out, m_err);
   end

   task automatic clr_in();
      in_valid = 0; ALUoutIn = '0; RtIn = '0; MemEnableIn = 0; MemWrIn = 0; HaltIn = 0;
      Val2RegIn = 0; RegWrIn = 0; WrRegIn = '0; mem_ready = 0; mem_rdata = '0;
   endtask

   task automatic issue(input logic [15:0] alu, input logic [15:0] rt, input logic men,
                        input logic mwr, input logic hlt, input logic v2r, input logic rw,
                        input logic [2:0] wr);
      in_valid = 1; ALUoutIn = alu; RtIn = rt; MemEnableIn = men; MemWrIn = mwr;
      HaltIn = hlt; Val2RegIn = v2r; RegWrIn = rw; WrRegIn = wr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 0;
      #2;
      rst = 1;
   endtask

   task automatic rand_instr();
      logic [15:0] a;
      in_valid    = ($urandom_range(0, 9) < 8);
      HaltIn      = ($urandom_range(0, 99) < 2);
      MemEnableIn = ($urandom_range(0, 9) < 4);
      MemWrIn     = 1'($urandom_range(0, 1));
      Val2RegIn   = 1'($urandom_range(0, 1));
      RegWrIn     = 1'($urandom_range(0, 1));
      WrRegIn     = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      if ($urandom_range(0, 99) >= 5) a[0] = 1'b0;
      ALUoutIn = a;
      RtIn     = 16'($urandom);
   endtask

   int  cnt_a, cnt_b, halt_cycles;
   bit  adv;

   initial begin
      rst = 0;
      clr_in();
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_wb_valid", wb_valid, 1'b0);
      chk16("rst_wb_data", wb_data, 16'h0000);
      chk16("rst_wb_reg", 16'(wb_reg), 16'h0000);
      chk1("rst_halt", halt_out, 1'b0);
      chk1("rst_err", err_out, 1'b0);
      chk1("rst_mem_req", mem_req, 1'b0);
      chk16("rst_mem_addr", mem_addr, 16'h0000);
      chk16("rst_mem_wdata", mem_wdata, 16'h0000);
      rst = 1;

      // ALU op
      step();
      issue(16'h1234, 16'h0, 0, 0, 0, 0, 1, 3'd5);
      #1;
      chk1("alu_stall", stall, 1'b0);
      step();
      clr_in();
      chk1("alu_wb_valid", wb_valid, 1'b1);
      chk16("alu_wb_data", wb_data, 16'h1234);
      chk16("alu_wb_reg", 16'(wb_reg), 16'h0005);
      chk1("alu_wb_regwr", wb_regwr, 1'b1);
      step();
      chk1("alu_one_shot", wb_valid, 1'b0);

      // load, ready on first REQ cycle
      issue(16'h0040, 16'h0, 1, 0, 0, 1, 1, 3'd2);
      #1;
      chk1("ld_stall_issue", stall, 1'b1);
      chk1("ld_req_issue", mem_req, 1'b0);
      step();
      chk1("ld_req", mem_req, 1'b1);
      chk16("ld_addr", mem_addr, 16'h0040);
      chk1("ld_wr", mem_wr, 1'b0);
      mem_ready = 1; mem_rdata = 16'hBEEF;
      #1;
      chk1("ld_stall_ready", stall, 1'b0);
      step();
      clr_in();
      chk1("ld_wb_valid", wb_valid, 1'b1);
      chk16("ld_wb_data", wb_data, 16'hBEEF);
      chk1("ld_req_done", mem_req, 1'b0);

      // store, 3 wait cycles
      issue(16'h0010, 16'hA5A5, 1, 1, 0, 0, 0, 3'd3);
      #1;
      chk1("st_stall_issue", stall, 1'b1);
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         mem_ready = (i == 3);
         mem_rdata = 16'($urandom);
         #1;
         if (mem_wr && mem_addr == 16'h0010 && mem_wdata == 16'hA5A5) cnt_a++;
         if (stall) cnt_b++;
      end
      chk16("st_wr_cycles", 16'(cnt_a), 16'd4);
      chk16("st_stall_waits", 16'(cnt_b), 16'd3);
      step();
      clr_in();
      chk1("st_wb_valid", wb_valid, 1'b1);
      chk1("st_wb_regwr", wb_regwr, 1'b0);
      chk16("st_wb_data", wb_data, 16'h0010);

      // misaligned load
      issue(16'h0003, 16'h0, 1, 0, 0, 1, 1, 3'd1);
      #1;
      chk1("mis_stall", stall, 1'b1);
      chk1("mis_req", mem_req, 1'b0);
      step();
      chk1("mis_err", err_out, 1'b1);
      chk1("mis_halt", halt_out, 1'b1);
      chk1("mis_wb_valid", wb_valid, 1'b0);
      clr_in();
      issue(16'h0042, 16'h0, 0, 0, 0, 0, 1, 3'd1);
      step();
      chk1("mis_absorb_wb", wb_valid, 1'b0);
      chk1("mis_absorb_req", mem_req, 1'b0);
      clr_in();
      do_reset();

      // timeout
      step();
      issue(16'h0020, 16'h0, 1, 0, 0, 1, 1, 3'd4);
      cnt_a = 0;
      for (int i = 0; i < 12 && !err_out; i++) begin
         step();
         if (mem_req) cnt_a++;
      end
      chk16("tmo_req_cycles", 16'(cnt_a), 16'd4);
      chk1("tmo_err", err_out, 1'b1);
      chk1("tmo_halt", halt_out, 1'b1);
      chk1("tmo_req_drop", mem_req, 1'b0);
      chk1("tmo_stall", stall, 1'b1);
      issue(16'h0050, 16'h0, 0, 0, 0, 0, 1, 3'd1);
      mem_ready = 1;
      step();
      step();
      chk1("tmo_ignore_wb", wb_valid, 1'b0);
      chk1("tmo_ignore_req", mem_req, 1'b0);
      clr_in();
      do_reset();

      // HALT with memory enable: halt wins
      step();
      issue(16'h0776, 16'h0, 1, 0, 1, 0, 1, 3'd6);
      #1;
      chk1("hlt_stall_issue", stall, 1'b0);
      step();
      clr_in();
      chk1("hlt_wb_valid", wb_valid, 1'b1);
      chk1("hlt_wb_regwr", wb_regwr, 1'b0);
      chk16("hlt_wb_data", wb_data, 16'h0776);
      chk1("hlt_halt", halt_out, 1'b1);
      chk1("hlt_req", mem_req, 1'b0);
      issue(16'h0100, 16'h0, 1, 0, 0, 1, 1, 3'd1);
      step();
      chk1("hlt_sticky_stall", stall, 1'b1);
      chk1("hlt_sticky_halt", halt_out, 1'b1);
      chk1("hlt_sticky_req", mem_req, 1'b0);
      clr_in();
      do_reset();

      // reset in the middle of REQ
      step();
      issue(16'h0100, 16'h0, 1, 0, 0, 1, 1, 3'd1);
      step();
      chk1("rreq_req", mem_req, 1'b1);
      #1;
      rst = 0;
      clr_in();
      #1;
      chk1("rreq_req_drop", mem_req, 1'b0);
      chk16("rreq_addr", mem_addr, 16'h0000);
      chk1("rreq_stall", stall, 1'b0);
      chk1("rreq_flags", wb_valid | wb_regwr | halt_out | err_out, 1'b0);
      #1;
      rst = 1;
      step();
      issue(16'h00AA, 16'h0, 0, 0, 0, 0, 1, 3'd7);
      step();
      clr_in();
      chk1("post_rst_wb_valid", wb_valid, 1'b1);
      chk16("post_rst_wb_data", wb_data, 16'h00AA);

      // random traffic
      halt_cycles = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         adv = !m_stall();
         @(posedge clk);
         #1;
         if (m_halted) begin
            halt_cycles++;
            if (halt_cycles > 2) begin
               do_reset();
               halt_cycles = 0;
            end
         end
         if (adv) rand_instr();
         mem_ready = ($urandom_range(0, 9) < 6);
         mem_rdata = 16'($urandom);
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
